// File: rtl/approx_mult_err_scan.sv
// Exhaustive error-characterisation sweep for a W x W multiplier of fixed latency LAT.
// Define ERR_MAX_TRACK_EN to also track the largest single error distance on max_ed.
module approx_mult_err_scan #(
  parameter int W   = 4,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   dut_y,
  output logic [2*W:0]     n_correct,
  output logic [4*W-1:0]   sum_ed,
  output logic [2*W-1:0]   max_ed
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  logic [1:0]     state;
  logic [2*W-1:0] k;
  logic [2:0]     drain_cnt;
  logic           launch;
  logic           issue;

  logic           cmp_v;
  logic [W-1:0]   cmp_a;
  logic [W-1:0]   cmp_b;
  logic [2*W-1:0] exact;
  logic [2*W-1:0] ed;
  logic           ed_zero;

  assign launch = start && ((state == S_IDLE) || (state == S_DONE));
  assign issue  = (state == S_RUN);
  assign busy   = (state == S_RUN) || (state == S_DRAIN);
  assign done   = (state == S_DONE);
  assign op_a   = issue ? k[2*W-1:W] : '0;
  assign op_b   = issue ? k[W-1:0]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_RUN;
            k     <= '0;
          end
        end
        S_RUN: begin
          if (k == '1) begin
            state     <= (LAT > 0) ? S_DRAIN : S_DONE;
            k         <= '0;
            drain_cnt <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operands travel alongside the multiplier pipeline so the compare sees the pair behind dut_y.
  generate
    if (LAT > 0) begin : g_delay
      logic         dl_v [LAT];
      logic [W-1:0] dl_a [LAT];
      logic [W-1:0] dl_b [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) begin
            dl_v[i] <= 1'b0;
            dl_a[i] <= '0;
            dl_b[i] <= '0;
          end
        end else begin
          dl_v[0] <= issue;
          dl_a[0] <= op_a;
          dl_b[0] <= op_b;
          for (int i = 1; i < LAT; i++) begin
            dl_v[i] <= dl_v[i-1];
            dl_a[i] <= dl_a[i-1];
            dl_b[i] <= dl_b[i-1];
          end
        end
      end

      assign cmp_v = dl_v[LAT-1];
      assign cmp_a = dl_a[LAT-1];
      assign cmp_b = dl_b[LAT-1];
    end else begin : g_nodelay
      assign cmp_v = issue;
      assign cmp_a = op_a;
      assign cmp_b = op_b;
    end
  endgenerate

  assign exact   = {{W{1'b0}}, cmp_a} * {{W{1'b0}}, cmp_b};
  assign ed      = (dut_y >= exact) ? (dut_y - exact) : (exact - dut_y);
  assign ed_zero = (ed == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      n_correct <= '0;
      sum_ed    <= '0;
    end else if (launch) begin
      n_correct <= '0;
      sum_ed    <= '0;
    end else if (cmp_v) begin
      n_correct <= n_correct + {{(2*W){1'b0}}, ed_zero};
      sum_ed    <= sum_ed + {{(2*W){1'b0}}, ed};
    end
  end

`ifdef ERR_MAX_TRACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_ed <= '0;
    end else if (launch) begin
      max_ed <= '0;
    end else if (cmp_v && (ed > max_ed)) begin
      max_ed <= ed;
    end
  end
`else
  assign max_ed = '0;
`endif

endmodule

// File: tb/tb_approx_mult_err_scan.sv
// Bench for approx_mult_err_scan: four sweep engines with different W/LAT and multipliers,
// each checked every cycle against a pair-level model plus hand-computed totals.
module tb_approx_mult_err_scan;

  logic clk;
  logic rst;
  logic [3:0] start_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [31:0] opa_o [4];
  logic [31:0] opb_o [4];
  logic [31:0] nc_o  [4];
  logic [31:0] sum_o [4];
  logic [31:0] max_o [4];

  int  checks;
  int  failures;
  bit  cmp_en;
  bit  armed_m [4];
  int  j_m     [4];

`ifdef ERR_MAX_TRACK_EN
  localparam bit MAX_ON = 1'b1;
`else
  localparam bit MAX_ON = 1'b0;
`endif

  // Instance 0: W=4 LAT=0 exact multiplier
  logic [3:0] op_a0, op_b0;
  logic [7:0] y0;
  logic [8:0] nc0;
  logic [15:0] sum0;
  logic [7:0] max0;
  // Instance 1: W=2 LAT=0 approximate cell
  logic [1:0] op_a1, op_b1;
  logic [3:0] y1;
  logic [4:0] nc1;
  logic [7:0] sum1;
  logic [3:0] max1;
  // Instance 2: W=2 LAT=2 approximate cell registered twice
  logic [1:0] op_a2, op_b2;
  logic [3:0] y2, r2a, r2b;
  logic [4:0] nc2;
  logic [7:0] sum2;
  logic [3:0] max2;
  // Instance 3: W=3 LAT=1 exact+1 registered once
  logic [2:0] op_a3, op_b3;
  logic [5:0] y3, r3;
  logic [6:0] nc3;
  logic [11:0] sum3;
  logic [5:0] max3;

  function automatic logic [3:0] cell2(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd3 && b == 2'd3) ? 4'd7 : ({2'b00, a} * {2'b00, b});
  endfunction

  assign y0 = {4'b0, op_a0} * {4'b0, op_b0};
  assign y1 = cell2(op_a1, op_b1);
  assign y2 = r2b;
  assign y3 = r3;

  always @(posedge clk) begin
    r2a <= cell2(op_a2, op_b2);
    r2b <= r2a;
    r3  <= ({3'b0, op_a3} * {3'b0, op_b3}) + 6'd1;
  end

  approx_mult_err_scan #(.W(4), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .op_a(op_a0), .op_b(op_b0), .dut_y(y0), .n_correct(nc0), .sum_ed(sum0), .max_ed(max0));
  approx_mult_err_scan #(.W(2), .LAT(0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .op_a(op_a1), .op_b(op_b1), .dut_y(y1), .n_correct(nc1), .sum_ed(sum1), .max_ed(max1));
  approx_mult_err_scan #(.W(2), .LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .op_a(op_a2), .op_b(op_b2), .dut_y(y2), .n_correct(nc2), .sum_ed(sum2), .max_ed(max2));
  approx_mult_err_scan #(.W(3), .LAT(1)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .op_a(op_a3), .op_b(op_b3), .dut_y(y3), .n_correct(nc3), .sum_ed(sum3), .max_ed(max3));

  assign opa_o[0] = 32'(op_a0);  assign opb_o[0] = 32'(op_b0);
  assign nc_o[0]  = 32'(nc0);    assign sum_o[0] = 32'(sum0);   assign max_o[0] = 32'(max0);
  assign opa_o[1] = 32'(op_a1);  assign opb_o[1] = 32'(op_b1);
  assign nc_o[1]  = 32'(nc1);    assign sum_o[1] = 32'(sum1);   assign max_o[1] = 32'(max1);
  assign opa_o[2] = 32'(op_a2);  assign opb_o[2] = 32'(op_b2);
  assign nc_o[2]  = 32'(nc2);    assign sum_o[2] = 32'(sum2);   assign max_o[2] = 32'(max2);
  assign opa_o[3] = 32'(op_a3);  assign opb_o[3] = 32'(op_b3);
  assign nc_o[3]  = 32'(nc3);    assign sum_o[3] = 32'(sum3);   assign max_o[3] = 32'(max3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int inst_w(input int i);
    case (i)
      0: return 4;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int inst_lat(input int i);
    case (i)
      2: return 2;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  // Product the multiplier attached to instance i returns for operands a, b.
  function automatic int ref_prod(input int i, input int a, input int b);
    int w;
    w = inst_w(i);
    case (i)
      1, 2: return (a == 3 && b == 3) ? 7 : a * b;
      3: return (a * b + 1) % (1 << (2 * w));
      default: return a * b;
    endcase
  endfunction

  // Expected outputs after the j-th edge following an accepted start.
  task automatic model_out(input int i, input int j, input bit armed,
                           output int e_busy, output int e_done, output int e_a, output int e_b,
                           output int e_nc, output int e_sum, output int e_max);
    int w, lat, n, cnt, pa, pb, ex, y, ed;
    e_busy = 0; e_done = 0; e_a = 0; e_b = 0; e_nc = 0; e_sum = 0; e_max = 0;
    if (armed) begin
      w   = inst_w(i);
      lat = inst_lat(i);
      n   = 1 << (2 * w);
      e_busy = (j < n + lat) ? 1 : 0;
      e_done = 1 - e_busy;
      if (j < n) begin
        e_a = j >> w;
        e_b = j & ((1 << w) - 1);
      end
      cnt = j - lat;
      if (cnt < 0) cnt = 0;
      if (cnt > n) cnt = n;
      for (int p = 0; p < cnt; p++) begin
        pa = p >> w;
        pb = p & ((1 << w) - 1);
        ex = pa * pb;
        y  = ref_prod(i, pa, pb);
        ed = (y > ex) ? y - ex : ex - y;
        if (ed == 0) e_nc++;
        e_sum += ed;
        if (MAX_ON && ed > e_max) e_max = ed;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int idx, input longint actual,
                             input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s[%0d] at %0t: got=%0d expected=%0d", name, idx, $time,
               actual, expected);
    end
  endtask

  // Start acceptance as seen by the model: ignored while a sweep is still in flight.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        armed_m[i] <= 1'b0;
        j_m[i]     <= 0;
      end else if (start_v[i] && (!armed_m[i] ||
                   j_m[i] >= (1 << (2 * inst_w(i))) + inst_lat(i))) begin
        armed_m[i] <= 1'b1;
        j_m[i]     <= 0;
      end else if (armed_m[i]) begin
        j_m[i] <= j_m[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    int eb, ed_, ea, ebb, enc, es, em;
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) begin
        model_out(i, j_m[i], armed_m[i], eb, ed_, ea, ebb, enc, es, em);
        checkOutput("busy", i, busy_v[i], eb);
        checkOutput("done", i, done_v[i], ed_);
        checkOutput("op_a", i, opa_o[i], ea);
        checkOutput("op_b", i, opb_o[i], ebb);
        checkOutput("n_correct", i, nc_o[i], enc);
        checkOutput("sum_ed", i, sum_o[i], es);
        checkOutput("max_ed", i, max_o[i], em);
      end
    end
  end

  // Pulse start on one engine and count edges from E0 until done is seen.
  task automatic applyStimulus(input int idx, input bit noise, output int cycles);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    cycles = 0;
    while (!done_v[idx] && cycles < 400) begin
      start_v[idx] = noise && (cycles % 40 == 20);
      @(negedge clk);
      cycles++;
    end
    start_v[idx] = 1'b0;
    if (!done_v[idx]) checkOutput("done_timeout", idx, 0, 1);
  endtask

  initial begin
    int cyc;
    int pulses;
    checks = 0;
    failures = 0;
    cmp_en = 1'b0;
    rst = 1'b1;
    start_v = 4'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 0, busy_v[0], 0);
    checkOutput("reset_done", 0, done_v[0], 0);
    checkOutput("reset_n_correct", 0, nc_o[0], 0);

    $display("[TB] exact multiplier W=4 LAT=0");
    applyStimulus(0, 1'b0, cyc);
    checkOutput("done_edge", 0, cyc, 256);
    checkOutput("final_n_correct", 0, nc_o[0], 256);
    checkOutput("final_sum_ed", 0, sum_o[0], 0);
    checkOutput("final_max_ed", 0, max_o[0], 0);

    $display("[TB] approximate 2x2 cell W=2 LAT=0");
    applyStimulus(1, 1'b0, cyc);
    checkOutput("done_edge", 1, cyc, 16);
    checkOutput("final_n_correct", 1, nc_o[1], 15);
    checkOutput("final_sum_ed", 1, sum_o[1], 2);
    checkOutput("final_max_ed", 1, max_o[1], MAX_ON ? 2 : 0);

    $display("[TB] approximate 2x2 cell W=2 LAT=2");
    applyStimulus(2, 1'b0, cyc);
    checkOutput("done_edge", 2, cyc, 18);
    checkOutput("final_n_correct", 2, nc_o[2], 15);
    checkOutput("final_sum_ed", 2, sum_o[2], 2);
    checkOutput("final_max_ed", 2, max_o[2], MAX_ON ? 2 : 0);

    $display("[TB] exact+1 multiplier W=3 LAT=1");
    applyStimulus(3, 1'b0, cyc);
    checkOutput("done_edge", 3, cyc, 65);
    checkOutput("final_n_correct", 3, nc_o[3], 0);
    checkOutput("final_sum_ed", 3, sum_o[3], 64);
    checkOutput("final_max_ed", 3, max_o[3], MAX_ON ? 1 : 0);

    $display("[TB] reset at E10 of a W=4 sweep");
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 0, busy_v[0], 0);
    checkOutput("abort_op_b", 0, opb_o[0], 0);
    checkOutput("abort_n_correct", 0, nc_o[0], 0);
    checkOutput("abort_sum_ed", 0, sum_o[0], 0);

    $display("[TB] second W=4 sweep with start pulses while busy");
    applyStimulus(0, 1'b1, cyc);
    checkOutput("rerun_done_edge", 0, cyc, 256);
    checkOutput("rerun_n_correct", 0, nc_o[0], 256);
    checkOutput("rerun_sum_ed", 0, sum_o[0], 0);

    $display("[TB] start held high relaunches W=2 LAT=0");
    @(negedge clk);
    start_v[1] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_v[1]) pulses++;
    end
    start_v[1] = 1'b0;
    checkOutput("relaunch_done_pulses", 1, pulses, 2);
    cyc = 0;
    while (!done_v[1] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("relaunch_final_done", 1, done_v[1], 1);
    checkOutput("relaunch_n_correct", 1, nc_o[1], 15);
    checkOutput("relaunch_sum_ed", 1, sum_o[1], 2);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/approx_mult_err_scan.md
# approx_mult_err_scan

Parametrised hardware error-characterisation engine for the approximate recursive multipliers. On `start` it sweeps every operand pair of a W×W multiplier under test, compares the multiplier's product with the exact product, and accumulates the correct-result count and the total error distance. It replaces software exhaustive checking with a synthesizable block. It supports any operand width and pipelined multipliers of fixed latency.

## Interface
- `W`, default 4: operand width of the multiplier under test; legal range 2..8.
- `LAT`, default 0: multiplier latency in clock cycles; 0 means a combinational multiplier; legal range 0..7.
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sampled only in IDLE or DONE; begins a sweep.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; results stable.
- `op_a`  out  W  operand A driven to the multiplier under test.
- `op_b`  out  W  operand B driven to the multiplier under test.
- `dut_y`  in  2W  product returned by the multiplier under test.
- `n_correct`  out  2W+1  count of pairs with `dut_y` equal to the exact product.
- `sum_ed`  out  4W  sum of |dut_y − a·b| over all pairs.
- `max_ed`  out  2W  largest single error distance (see Configuration).

## Operation
- FSM states:
  - IDLE.
  - RUN: issue pairs.
  - DRAIN: wait for the last LAT results.
  - DONE.
- Reset forces IDLE. All outputs reset to 0: `busy`, `done`, `op_a`, `op_b`, `n_correct`, `sum_ed` and `max_ed`. The issue counter and the valid/operand delay line are also cleared.
- IDLE/DONE with `start` = 1 → RUN:
  - clears the accumulators and the counter k;
  - `done` drops.
- RUN behaviour:
  - k is a 2W-bit counter.
  - `op_a` = k[2W-1:W] and `op_b` = k[W-1:0]: A is the outer loop and B the inner loop, so the order is a=0,b=0..max, then a=1, and so on.
  - One pair is issued per cycle.
- RUN exit:
  - When k reaches 2^(2W)−1, that pair is issued and the FSM goes to DRAIN if LAT>0, else to DONE.
- DRAIN: stay for LAT cycles until the delay line is empty, then go to DONE.
- In IDLE, DRAIN and DONE, `op_a` and `op_b` are 0.
- Delay line: the issued operands and a valid bit are delayed LAT cycles. The compare stage sees the operands that produced the current `dut_y`.
- Compare stage, on a valid slot:
  - exact = a·b, 2W bits;
  - ed = |dut_y − exact|, 2W bits unsigned;
  - `n_correct` += (ed==0);
  - `sum_ed` += ed.
- Widths:
  - `n_correct` max is 2^(2W), which needs 2W+1 bits;
  - `sum_ed` max is below 2^(4W);
  - no overflow is possible, and no saturation logic is required.
- `start` is ignored while `busy`.
- `rst` asserted mid-sweep aborts immediately to IDLE with everything cleared. No partial results are retained.
- `start` held high in DONE re-launches a new sweep every time DONE is reached.

## Timing
- Start edge E0 is the edge at which `start` is sampled. Issue of pair k occupies the cycle after edge E(k).
- The pair issued after edge E(k) is accumulated at edge E(k+1+LAT).
- For LAT=0, `dut_y` is sampled at the end of the same cycle in which the pair is issued.
- The final accumulation occurs at E(2^(2W)+LAT). `done` rises at that same edge, with final values visible.
- `busy` is high from E0 to E(2^(2W)+LAT). `busy` and `done` are never both high.
- Total sweep time from `start` to `done` is 2^(2W)+LAT cycles.
- Accumulator outputs are registered and update at most once per cycle.

## Configuration
- Macro `ERR_MAX_TRACK_EN`.
- Defined:
  - `max_ed` is a register, cleared on start;
  - on each valid compare it is updated to max(`max_ed`, ed).
- Undefined:
  - the `max_ed` port still exists but is tied to 0;
  - no comparator or register is synthesised;
  - all other behaviour is identical.

## Test plan
- Exact multiplier as DUT, W=4, LAT=0, pulse `start`:
  - `done` rises at E256;
  - `n_correct`=256, `sum_ed`=0, `max_ed`=0.
- 2×2 approximate cell (3·3 → 7, all else exact), W=2, LAT=0:
  - `n_correct`=15, `sum_ed`=2;
  - `max_ed`=2 with the macro defined, 0 without.
- Same cell registered twice (LAT=2), W=2:
  - identical results;
  - `busy` high E0..E18, `done` at E18;
  - `op_a`/`op_b` sequence 0/0, 0/1 … 3/3 on consecutive cycles, then 0.
- DUT returning `dut_y` = exact+1 for every pair, W=3, LAT=1:
  - `n_correct`=0, `sum_ed`=64, `max_ed`=1.
- `rst` asserted at E10 of a W=4 sweep, then `start` again:
  - all outputs return to 0 on the reset edge;
  - the second sweep gives the full correct totals, with nothing carried over;
  - `start` pulses during `busy` have no effect.
